// File: rtl/tagged_req_cam.sv
// ----------------------------------------------------------------------------
// tagged_req_cam
//   Age-tracking CAM for outstanding memory requests. A push allocates the
//   lowest free slot and returns its index as the request tag. A pop frees a
//   slot by tag. LOOKUP_PORTS independent key searches report hit, the lowest
//   matching index and a duplicate-key flag. The least recently pushed live
//   entry is reported as the oldest entry.
//
//   Optional feature macro: TAGGED_CAM_FWD_EN
//     When defined, lookups also match the key of a push accepted in the same
//     cycle and report it at push_index. Registered entries keep priority.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   push_valid/push_ready allocation handshake (push_ready = !full)
//   push_index            tag handed out to a push in this cycle
//   data_in               payload stored on an accepted push
//   pop, pop_index        free the entry at pop_index
//   data_out              payload of entry pop_index (combinational)
//   lookup_key            LOOKUP_PORTS packed keys
//   lookup_hit/_index/_multi  per-port search results
//   count, full, empty    occupancy
//   oldest_valid/_index   oldest live entry
//   err_pop_invalid       sticky flag: pop of a free slot
// ----------------------------------------------------------------------------
module tagged_req_cam #(
  parameter int WIDTH        = 59,
  parameter int CAM_WIDTH    = 58,
  parameter int DEPTH        = 8,
  parameter int LOG_DEPTH    = 3,
  parameter int LOOKUP_PORTS = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push_valid,
  output logic                              push_ready,
  output logic [LOG_DEPTH-1:0]              push_index,
  input  logic [WIDTH-1:0]                  data_in,
  input  logic                              pop,
  input  logic [LOG_DEPTH-1:0]              pop_index,
  output logic [WIDTH-1:0]                  data_out,
  input  logic [LOOKUP_PORTS*CAM_WIDTH-1:0] lookup_key,
  output logic [LOOKUP_PORTS-1:0]           lookup_hit,
  output logic [LOOKUP_PORTS*LOG_DEPTH-1:0] lookup_index,
  output logic [LOOKUP_PORTS-1:0]           lookup_multi,
  output logic [LOG_DEPTH:0]                count,
  output logic                              full,
  output logic                              empty,
  output logic                              oldest_valid,
  output logic [LOG_DEPTH-1:0]              oldest_index,
  output logic                              err_pop_invalid
);

  logic [DEPTH-1:0]     valid_r;
  logic [WIDTH-1:0]     data_r [DEPTH];
  logic [LOG_DEPTH-1:0] age_r  [DEPTH];
  logic [LOG_DEPTH:0]   count_r;
  logic                 err_r;

  logic [DEPTH-1:0]     valid_nxt_s;
  logic [LOG_DEPTH-1:0] age_nxt_s [DEPTH];
  logic [LOG_DEPTH:0]   count_after_pop_s;
  logic [LOG_DEPTH:0]   count_nxt_s;
  logic [LOG_DEPTH-1:0] free_idx_s;
  logic                 free_found_s;
  logic                 full_s;
  logic                 push_acc_s;
  logic                 pop_ok_s;
  logic [LOG_DEPTH-1:0] pop_rank_s;
  logic [LOG_DEPTH-1:0] oldest_idx_s;
  logic [CAM_WIDTH-1:0] key_s;
  logic                 hit_s;
  logic                 multi_s;
  logic [LOG_DEPTH-1:0] idx_s;

  assign full_s     = (count_r == (LOG_DEPTH+1)'(DEPTH));
  assign push_acc_s = push_valid && !full_s;
  assign pop_ok_s   = pop && valid_r[pop_index];
  assign pop_rank_s = age_r[pop_index];

  // Lowest free slot from the pre-edge valid vector (0 when full).
  always_comb begin
    free_idx_s   = {LOG_DEPTH{1'b0}};
    free_found_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_r[i] && !free_found_s) begin
        free_idx_s   = LOG_DEPTH'(i);
        free_found_s = 1'b1;
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // Next valid/age/count state. Pops act before the push so the new entry's
  // rank equals the live count left after the pop.
  always_comb begin
    valid_nxt_s       = valid_r;
    count_after_pop_s = count_r - (LOG_DEPTH+1)'(pop_ok_s);
    count_nxt_s       = count_after_pop_s + (LOG_DEPTH+1)'(push_acc_s);
    for (int i = 0; i < DEPTH; i++) begin
      age_nxt_s[i] = age_r[i];
    end
    if (pop_ok_s) begin
      valid_nxt_s[pop_index] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_r[i] && (age_r[i] > pop_rank_s)) begin
          age_nxt_s[i] = age_r[i] - LOG_DEPTH'(1);
        end else begin
          age_nxt_s[i] = age_nxt_s[i];
        end
      end
    end else begin
      valid_nxt_s = valid_nxt_s;
    end
    // push slot is free, so it never collides with the popped slot
    if (push_acc_s) begin
      valid_nxt_s[free_idx_s] = 1'b1;
      age_nxt_s[free_idx_s]   = count_after_pop_s[LOG_DEPTH-1:0];
    end else begin
      valid_nxt_s = valid_nxt_s;
    end
  end

  // Control state register: valid bits, ranks, occupancy, sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= {DEPTH{1'b0}};
      count_r <= {(LOG_DEPTH+1){1'b0}};
      err_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        age_r[i] <= {LOG_DEPTH{1'b0}};
      end
    end else begin
      valid_r <= valid_nxt_s;
      count_r <= count_nxt_s;
      err_r   <= err_r | (pop && !valid_r[pop_index]);
      for (int i = 0; i < DEPTH; i++) begin
        age_r[i] <= age_nxt_s[i];
      end
    end
  end

  // Payload RAM, written on accepted push; intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      data_r[free_idx_s] <= data_in;
    end
  end

  // Oldest entry is the live slot holding rank 0.
  always_comb begin
    oldest_idx_s = {LOG_DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_r[i] && (age_r[i] == {LOG_DEPTH{1'b0}})) begin
        oldest_idx_s = LOG_DEPTH'(i);
      end else begin
        oldest_idx_s = oldest_idx_s;
      end
    end
  end

  // Per-port search: first match wins the index, any later match flags multi.
  always_comb begin
    lookup_hit   = {LOOKUP_PORTS{1'b0}};
    lookup_multi = {LOOKUP_PORTS{1'b0}};
    lookup_index = {(LOOKUP_PORTS*LOG_DEPTH){1'b0}};
    key_s        = {CAM_WIDTH{1'b0}};
    hit_s        = 1'b0;
    multi_s      = 1'b0;
    idx_s        = {LOG_DEPTH{1'b0}};
    for (int p = 0; p < LOOKUP_PORTS; p++) begin
      key_s   = lookup_key[p*CAM_WIDTH +: CAM_WIDTH];
      hit_s   = 1'b0;
      multi_s = 1'b0;
      idx_s   = {LOG_DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_r[i] && (data_r[i][CAM_WIDTH-1:0] == key_s)) begin
          multi_s = multi_s | hit_s;
          idx_s   = hit_s ? idx_s : LOG_DEPTH'(i);
          hit_s   = 1'b1;
        end else begin
          hit_s = hit_s;
        end
      end
`ifdef TAGGED_CAM_FWD_EN
      // forwarded push match only wins when no registered entry matched
      if (push_acc_s && (data_in[CAM_WIDTH-1:0] == key_s)) begin
        multi_s = multi_s | hit_s;
        idx_s   = hit_s ? idx_s : free_idx_s;
        hit_s   = 1'b1;
      end else begin
        hit_s = hit_s;
      end
`else
      hit_s = hit_s;
`endif
      lookup_hit[p]                        = hit_s;
      lookup_multi[p]                      = multi_s;
      lookup_index[p*LOG_DEPTH +: LOG_DEPTH] = idx_s;
    end
  end

  assign push_ready      = !full_s;
  assign push_index      = free_idx_s;
  assign data_out        = data_r[pop_index];
  assign count           = count_r;
  assign full            = full_s;
  assign empty           = (count_r == {(LOG_DEPTH+1){1'b0}});
  assign oldest_valid    = !empty;
  assign oldest_index    = oldest_idx_s;
  assign err_pop_invalid = err_r;

endmodule
